mips_id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the 5-stage core. Captures decoded operands and control from the ID stage each cycle and presents them to EX. Applies a WB→ID bypass for the same-cycle regfile write/read collision. Detects load-use hazards, inserts one bubble and stalls IF/ID, and handles EX back-pressure and branch flush.

---
 rtl/mips_id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_mips_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures decoded operands and control from ID and presents them to EX.
// Also provides the same-cycle WB->ID bypass, load-use hazard detection with a
// one-cycle bubble, EX back-pressure hold and branch flush.

`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif

module mips_id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // ID side
  input  logic                          id_valid_i,
  input  logic [`MIPS_DATA_WIDTH-1:0]   id_pc_i,
  input  logic [`MIPS_RFIDX_WIDTH-1:0]  id_rs_idx_i,
  input  logic [`MIPS_RFIDX_WIDTH-1:0]  id_rt_idx_i,
  input  logic [`MIPS_DATA_WIDTH-1:0]   id_rs_dat_i,
  input  logic [`MIPS_DATA_WIDTH-1:0]   id_rt_dat_i,
  input  logic [`MIPS_DATA_WIDTH-1:0]   id_imm_i,
  input  logic [3:0]                    id_alu_op_i,
  input  logic                          id_dest_en_i,
  input  logic [`MIPS_RFIDX_WIDTH-1:0]  id_dest_idx_i,
  input  logic                          id_mem_rd_i,
  input  logic                          id_mem_wr_i,
  // WB write port (same signals that drive the regfile)
  input  logic                          wb_dest_en_i,
  input  logic [`MIPS_RFIDX_WIDTH-1:0]  wb_dest_idx_i,
  input  logic [`MIPS_DATA_WIDTH-1:0]   wb_dest_dat_i,
  // EX handshake
  input  logic                          ex_ready_i,
  input  logic                          ex_flush_i,
  // outputs
  output logic                          id_stall_o,
  output logic                          ex_valid_o,
  output logic [`MIPS_DATA_WIDTH-1:0]   ex_pc_o,
  output logic [`MIPS_DATA_WIDTH-1:0]   ex_rs_dat_o,
  output logic [`MIPS_DATA_WIDTH-1:0]   ex_rt_dat_o,
  output logic [`MIPS_DATA_WIDTH-1:0]   ex_imm_o,
  output logic [`MIPS_RFIDX_WIDTH-1:0]  ex_rs_idx_o,
  output logic [`MIPS_RFIDX_WIDTH-1:0]  ex_rt_idx_o,
  output logic [`MIPS_RFIDX_WIDTH-1:0]  ex_dest_idx_o,
  output logic [3:0]                    ex_alu_op_o,
  output logic                          ex_dest_en_o,
  output logic                          ex_mem_rd_o,
  output logic                          ex_mem_wr_o,
  output logic [CNT_W-1:0]              bubble_cnt_o
);

  localparam int DW = `MIPS_DATA_WIDTH;
  localparam int RW = `MIPS_RFIDX_WIDTH;

  // Contents of the EX slot. valid/dest_en/mem_rd/mem_wr are the control
  // fields that are killed by flush and bubbles; everything else is data.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [DW-1:0] rs_dat;
    logic [DW-1:0] rt_dat;
    logic [DW-1:0] imm;
    logic [3:0]    alu_op;
    logic          dest_en;
    logic [RW-1:0] dest_idx;
    logic          mem_rd;
    logic          mem_wr;
  } ex_slot_t;

  ex_slot_t         slot_q, slot_d;
  ex_slot_t         id_slot;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [DW-1:0]    rs_fwd, rt_fwd;
  logic             hz;

  // WB->ID bypass: a regfile write in this same cycle is not yet visible on
  // the read ports, so take it from the write bus. r0 is hard-wired zero.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned and infers a latch.
    rs_fwd = id_rs_dat_i;
    rt_fwd = id_rt_dat_i;
    if (wb_dest_en_i && (wb_dest_idx_i != '0) && (wb_dest_idx_i == id_rs_idx_i))
      rs_fwd = wb_dest_dat_i;
    if (wb_dest_en_i && (wb_dest_idx_i != '0) && (wb_dest_idx_i == id_rt_idx_i))
      rt_fwd = wb_dest_dat_i;
  end

  // Load in EX feeding the instruction in ID. rt is compared even when the
  // ID instruction does not read it; the extra stall is harmless.
  assign hz = id_valid_i & slot_q.valid & slot_q.mem_rd & slot_q.dest_en &
              (slot_q.dest_idx != '0) &
              ((slot_q.dest_idx == id_rs_idx_i) | (slot_q.dest_idx == id_rt_idx_i));

  // A flush discards the ID instruction, so IF/ID must be free to reload.
  assign id_stall_o = ~ex_flush_i & (~ex_ready_i | hz);

  // Instruction as it would enter EX; control zeroed if ID holds nothing.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid_i;
    id_slot.pc       = id_pc_i;
    id_slot.rs_idx   = id_rs_idx_i;
    id_slot.rt_idx   = id_rt_idx_i;
    id_slot.rs_dat   = rs_fwd;
    id_slot.rt_dat   = rt_fwd;
    id_slot.imm      = id_imm_i;
    id_slot.alu_op   = id_alu_op_i;
    id_slot.dest_idx = id_dest_idx_i;
    id_slot.dest_en  = id_valid_i & id_dest_en_i;
    id_slot.mem_rd   = id_valid_i & id_mem_rd_i;
    id_slot.mem_wr   = id_valid_i & id_mem_wr_i;
  end

  // Next-state selection: flush > back-pressure hold > bubble > load.
  always_comb begin
    slot_d       = slot_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ex_flush_i) begin
      slot_d.valid   = 1'b0;
      slot_d.dest_en = 1'b0;
      slot_d.mem_rd  = 1'b0;
      slot_d.mem_wr  = 1'b0;
    end else if (!ex_ready_i) begin
      slot_d = slot_q;
    end else if (hz) begin
      slot_d.valid   = 1'b0;
      slot_d.dest_en = 1'b0;
      slot_d.mem_rd  = 1'b0;
      slot_d.mem_wr  = 1'b0;
      if (bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      slot_d = id_slot;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      slot_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      slot_q       <= slot_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o    = slot_q.valid;
  assign ex_pc_o       = slot_q.pc;
  assign ex_rs_dat_o   = slot_q.rs_dat;
  assign ex_rt_dat_o   = slot_q.rt_dat;
  assign ex_imm_o      = slot_q.imm;
  assign ex_rs_idx_o   = slot_q.rs_idx;
  assign ex_rt_idx_o   = slot_q.rt_idx;
  assign ex_dest_idx_o = slot_q.dest_idx;
  assign ex_alu_op_o   = slot_q.alu_op;
  assign ex_dest_en_o  = slot_q.dest_en;
  assign ex_mem_rd_o   = slot_q.mem_rd;
  assign ex_mem_wr_o   = slot_q.mem_wr;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Self-checking bench for mips_id_ex_stage: a directed vector table for
// straight-line flow, then hand sequences for back-pressure, flush, reset
// mid-stall and bubble counter saturation (second instance with CNT_W=2).

module tb_mips_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_dat, id_rt_dat, id_imm;
  logic [4:0]  id_rs_idx, id_rt_idx, id_dest_idx;
  logic [3:0]  id_alu_op;
  logic        id_dest_en, id_mem_rd, id_mem_wr;
  logic        wb_dest_en;
  logic [4:0]  wb_dest_idx;
  logic [31:0] wb_dest_dat;
  logic        ex_ready, ex_flush;

  logic        id_stall, ex_valid, ex_dest_en, ex_mem_rd, ex_mem_wr;
  logic [31:0] ex_pc, ex_rs_dat, ex_rt_dat, ex_imm;
  logic [4:0]  ex_rs_idx, ex_rt_idx, ex_dest_idx;
  logic [3:0]  ex_alu_op;
  logic [15:0] bubble_cnt;

  logic        s_id_stall, s_ex_valid, s_ex_dest_en, s_ex_mem_rd, s_ex_mem_wr;
  logic [31:0] s_ex_pc, s_ex_rs_dat, s_ex_rt_dat, s_ex_imm;
  logic [4:0]  s_ex_rs_idx, s_ex_rt_idx, s_ex_dest_idx;
  logic [3:0]  s_ex_alu_op;
  logic [1:0]  s_bubble_cnt;

  int total = 0;
  int bad   = 0;

  mips_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs_idx_i(id_rs_idx), .id_rt_idx_i(id_rt_idx),
    .id_rs_dat_i(id_rs_dat), .id_rt_dat_i(id_rt_dat),
    .id_imm_i(id_imm), .id_alu_op_i(id_alu_op),
    .id_dest_en_i(id_dest_en), .id_dest_idx_i(id_dest_idx),
    .id_mem_rd_i(id_mem_rd), .id_mem_wr_i(id_mem_wr),
    .wb_dest_en_i(wb_dest_en), .wb_dest_idx_i(wb_dest_idx), .wb_dest_dat_i(wb_dest_dat),
    .ex_ready_i(ex_ready), .ex_flush_i(ex_flush),
    .id_stall_o(id_stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs_dat_o(ex_rs_dat), .ex_rt_dat_o(ex_rt_dat), .ex_imm_o(ex_imm),
    .ex_rs_idx_o(ex_rs_idx), .ex_rt_idx_o(ex_rt_idx), .ex_dest_idx_o(ex_dest_idx),
    .ex_alu_op_o(ex_alu_op), .ex_dest_en_o(ex_dest_en),
    .ex_mem_rd_o(ex_mem_rd), .ex_mem_wr_o(ex_mem_wr),
    .bubble_cnt_o(bubble_cnt)
  );

  mips_id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs_idx_i(id_rs_idx), .id_rt_idx_i(id_rt_idx),
    .id_rs_dat_i(id_rs_dat), .id_rt_dat_i(id_rt_dat),
    .id_imm_i(id_imm), .id_alu_op_i(id_alu_op),
    .id_dest_en_i(id_dest_en), .id_dest_idx_i(id_dest_idx),
    .id_mem_rd_i(id_mem_rd), .id_mem_wr_i(id_mem_wr),
    .wb_dest_en_i(wb_dest_en), .wb_dest_idx_i(wb_dest_idx), .wb_dest_dat_i(wb_dest_dat),
    .ex_ready_i(ex_ready), .ex_flush_i(ex_flush),
    .id_stall_o(s_id_stall), .ex_valid_o(s_ex_valid), .ex_pc_o(s_ex_pc),
    .ex_rs_dat_o(s_ex_rs_dat), .ex_rt_dat_o(s_ex_rt_dat), .ex_imm_o(s_ex_imm),
    .ex_rs_idx_o(s_ex_rs_idx), .ex_rt_idx_o(s_ex_rt_idx), .ex_dest_idx_o(s_ex_dest_idx),
    .ex_alu_op_o(s_ex_alu_op), .ex_dest_en_o(s_ex_dest_en),
    .ex_mem_rd_o(s_ex_mem_rd), .ex_mem_wr_o(s_ex_mem_wr),
    .bubble_cnt_o(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // ID instruction and WB port
    logic        idv;
    logic [31:0] pc;
    logic [4:0]  rsi;
    logic [31:0] rsd;
    logic [4:0]  rti;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        de;
    logic [4:0]  di;
    logic        mr, mw;
    logic        we;
    logic [4:0]  wi;
    logic [31:0] wd;
    // expected: stall before the edge, EX slot after it
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rsi;
    logic [31:0] e_rsd;
    logic [4:0]  e_rti;
    logic [31:0] e_rtd;
    logic [31:0] e_imm;
    logic [3:0]  e_op;
    logic [2:0]  e_ctrl;   // {dest_en, mem_rd, mem_wr}
    logic [4:0]  e_di;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rsi,
                        input logic [31:0] rsd, input logic [4:0] rti, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [3:0] op, input logic de,
                        input logic [4:0] di, input logic mr, input logic mw);
    id_valid = v;     id_pc = pc;
    id_rs_idx = rsi;  id_rs_dat = rsd;
    id_rt_idx = rti;  id_rt_dat = rtd;
    id_imm = imm;     id_alu_op = op;
    id_dest_en = de;  id_dest_idx = di;
    id_mem_rd = mr;   id_mem_wr = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [2:0] ctrl, input logic [15:0] cnt);
    check({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, v});
    check({tag, ".pc"}, ex_pc, pc);
    check({tag, ".ctrl"}, {29'b0, ex_dest_en, ex_mem_rd, ex_mem_wr}, {29'b0, ctrl});
    check({tag, ".cnt"}, {16'b0, bubble_cnt}, {16'b0, cnt});
  endtask

  initial begin
    // idv pc         rsi rsd        rti rtd      imm           op de di  mr mw we wi wd   | stall v pc   rsi rsd  rti rtd  imm op ctrl di cnt
    vt[0]  = '{1, 32'h00400010, 3, 32'h11,   4, 32'h22,   32'hFFFFFFF8, 2, 1, 7, 0, 0, 0, 0, 32'h0,
               0, 1, 32'h00400010, 3, 32'h11,   4, 32'h22,   32'hFFFFFFF8, 2, 3'b100, 7, 0};
    vt[1]  = '{1, 32'h00400014, 5, 32'hAAAA, 6, 32'h66,   32'h4,  1, 1, 2, 0, 0, 1, 5, 32'h1234,
               0, 1, 32'h00400014, 5, 32'h1234, 6, 32'h66,   32'h4,  1, 3'b100, 2, 0};
    vt[2]  = '{1, 32'h00400018, 0, 32'hAAAA, 7, 32'h77,   32'hC,  3, 0, 0, 0, 1, 1, 0, 32'h1234,
               0, 1, 32'h00400018, 0, 32'hAAAA, 7, 32'h77,   32'hC,  3, 3'b001, 0, 0};
    vt[3]  = '{1, 32'h00400020, 1, 32'h1000, 9, 32'h99,   32'h10, 0, 1, 8, 1, 0, 1, 9, 32'hBEEF,
               0, 1, 32'h00400020, 1, 32'h1000, 9, 32'hBEEF, 32'h10, 0, 3'b110, 8, 0};
    vt[4]  = '{1, 32'h00400024, 8, 32'h55,   1, 32'h1000, 32'h0,  2, 1, 9, 0, 0, 0, 0, 32'h0,
               1, 0, 32'h00400020, 1, 32'h1000, 9, 32'hBEEF, 32'h10, 0, 3'b000, 8, 1};
    vt[5]  = '{1, 32'h00400024, 8, 32'h55,   1, 32'h1000, 32'h0,  2, 1, 9, 0, 0, 0, 0, 32'h0,
               0, 1, 32'h00400024, 8, 32'h55,   1, 32'h1000, 32'h0,  2, 3'b100, 9, 1};
    vt[6]  = '{1, 32'h00400028, 2, 32'h200,  3, 32'h300,  32'h8,  0, 1, 0, 1, 0, 0, 0, 32'h0,
               0, 1, 32'h00400028, 2, 32'h200,  3, 32'h300,  32'h8,  0, 3'b110, 0, 1};
    vt[7]  = '{1, 32'h0040002C, 0, 32'h0,    0, 32'h0,    32'h1,  3, 1, 10, 0, 0, 0, 0, 32'h0,
               0, 1, 32'h0040002C, 0, 32'h0,    0, 32'h0,    32'h1,  3, 3'b100, 10, 1};
    vt[8]  = '{0, 32'h00400030, 4, 32'h44,   5, 32'h45,   32'h2,  5, 1, 11, 1, 1, 0, 0, 32'h0,
               0, 0, 32'h00400030, 4, 32'h44,   5, 32'h45,   32'h2,  5, 3'b000, 11, 1};
    vt[9]  = '{1, 32'h00400034, 4, 32'h4000, 12, 32'h0,   32'h0,  0, 1, 12, 1, 0, 0, 0, 32'h0,
               0, 1, 32'h00400034, 4, 32'h4000, 12, 32'h0,   32'h0,  0, 3'b110, 12, 1};
    vt[10] = '{1, 32'h00400038, 3, 32'h3,    12, 32'hC,   32'h4,  0, 0, 0, 0, 1, 0, 0, 32'h0,
               1, 0, 32'h00400034, 4, 32'h4000, 12, 32'h0,   32'h0,  0, 3'b000, 12, 2};
    vt[11] = '{1, 32'h00400038, 3, 32'h3,    12, 32'hC,   32'h4,  0, 0, 0, 0, 1, 0, 0, 32'h0,
               0, 1, 32'h00400038, 3, 32'h3,    12, 32'hC,   32'h4,  0, 3'b001, 0, 2};
    vt[12] = '{1, 32'h0040003C, 0, 32'h0,    0, 32'h0,    32'h0,  0, 1, 13, 1, 0, 0, 0, 32'h0,
               0, 1, 32'h0040003C, 0, 32'h0,    0, 32'h0,    32'h0,  0, 3'b110, 13, 2};
    vt[13] = '{0, 32'h00400040, 13, 32'h7,   13, 32'h8,   32'h0,  2, 1, 14, 0, 0, 0, 0, 32'h0,
               0, 0, 32'h00400040, 13, 32'h7,  13, 32'h8,   32'h0,  2, 3'b000, 14, 2};

    // ---------------- reset with arbitrary inputs ----------------
    rst_n = 1'b0;
    ex_ready = 1'b1; ex_flush = 1'b0;
    wb_dest_en = 1'b1; wb_dest_idx = 5'd3; wb_dest_dat = 32'hCAFE_F00D;
    set_id(1, 32'hDEAD_BEEF, 5'd3, 32'h5555, 5'd7, 32'h7777, 32'h1, 4'hF, 1, 5'd9, 1, 1);
    tick();
    check_slot("reset", 0, 32'h0, 3'b000, 16'd0);
    check("reset.rs_dat", ex_rs_dat, 32'h0);
    check("reset.alu_op", {28'b0, ex_alu_op}, 32'h0);
    check("reset.dest_idx", {27'b0, ex_dest_idx}, 32'h0);
    check("reset.sat_cnt", {30'b0, s_bubble_cnt}, 32'h0);
    check("reset.stall", {31'b0, id_stall}, 32'h0);
    rst_n = 1'b1;
    wb_dest_en = 1'b0;

    // ---------------- table: straight-line flow ----------------
    for (int i = 0; i < 14; i++) begin
      set_id(vt[i].idv, vt[i].pc, vt[i].rsi, vt[i].rsd, vt[i].rti, vt[i].rtd,
             vt[i].imm, vt[i].op, vt[i].de, vt[i].di, vt[i].mr, vt[i].mw);
      wb_dest_en = vt[i].we; wb_dest_idx = vt[i].wi; wb_dest_dat = vt[i].wd;
      #1;
      check($sformatf("v%0d.stall", i), {31'b0, id_stall}, {31'b0, vt[i].e_stall});
      tick();
      check_slot($sformatf("v%0d", i), vt[i].e_valid, vt[i].e_pc, vt[i].e_ctrl, vt[i].e_cnt);
      check($sformatf("v%0d.rs_idx", i), {27'b0, ex_rs_idx}, {27'b0, vt[i].e_rsi});
      check($sformatf("v%0d.rs_dat", i), ex_rs_dat, vt[i].e_rsd);
      check($sformatf("v%0d.rt_idx", i), {27'b0, ex_rt_idx}, {27'b0, vt[i].e_rti});
      check($sformatf("v%0d.rt_dat", i), ex_rt_dat, vt[i].e_rtd);
      check($sformatf("v%0d.imm", i), ex_imm, vt[i].e_imm);
      check($sformatf("v%0d.alu_op", i), {28'b0, ex_alu_op}, {28'b0, vt[i].e_op});
      check($sformatf("v%0d.dest_idx", i), {27'b0, ex_dest_idx}, {27'b0, vt[i].e_di});
    end
    wb_dest_en = 1'b0;
    check("tbl.sat_cnt", {30'b0, s_bubble_cnt}, 32'd2);

    // ---------------- back-pressure with pending hazard, then flush ----------------
    set_id(1, 32'h100, 5'd1, 32'h10, 5'd2, 32'h20, 32'h4, 4'd0, 1, 5'd13, 1, 0);
    tick();
    check_slot("bp.load", 1, 32'h100, 3'b110, 16'd2);
    set_id(1, 32'h104, 5'd13, 32'h99, 5'd4, 32'h44, 32'h0, 4'd2, 1, 5'd14, 0, 0);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d.stall", c), {31'b0, id_stall}, 32'd1);
      tick();
      check_slot($sformatf("bp%0d", c), 1, 32'h100, 3'b110, 16'd2);
      check($sformatf("bp%0d.rs_dat", c), ex_rs_dat, 32'h10);
    end
    ex_flush = 1'b1;
    #1;
    check("bpflush.stall", {31'b0, id_stall}, 32'd0);
    tick();
    check_slot("bpflush", 0, 32'h100, 3'b000, 16'd2);
    check("bpflush.dest_idx", {27'b0, ex_dest_idx}, 32'd13);
    ex_flush = 1'b0;
    ex_ready = 1'b1;

    // ---------------- flush beats a load-use hazard ----------------
    set_id(1, 32'h200, 5'd1, 32'h10, 5'd2, 32'h20, 32'h4, 4'd0, 1, 5'd13, 1, 0);
    tick();
    set_id(1, 32'h204, 5'd4, 32'h99, 5'd13, 32'h44, 32'h0, 4'd2, 1, 5'd14, 0, 0);
    ex_flush = 1'b1;
    #1;
    check("hzflush.stall", {31'b0, id_stall}, 32'd0);
    tick();
    check_slot("hzflush", 0, 32'h200, 3'b000, 16'd2);
    ex_flush = 1'b0;

    // ---------------- reset asserted while stalled ----------------
    set_id(1, 32'h300, 5'd1, 32'h10, 5'd2, 32'h20, 32'h4, 4'd0, 1, 5'd13, 1, 0);
    tick();
    set_id(1, 32'h304, 5'd13, 32'h99, 5'd4, 32'h44, 32'h0, 4'd2, 1, 5'd14, 0, 0);
    rst_n = 1'b0;
    #1;
    check("rststall.stall_before", {31'b0, id_stall}, 32'd1);
    tick();
    check_slot("rststall", 0, 32'h0, 3'b000, 16'd0);
    check("rststall.sat_cnt", {30'b0, s_bubble_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rststall.stall_after", {31'b0, id_stall}, 32'd0);

    // ---------------- five load-use bubbles: counter saturation ----------------
    for (int k = 1; k <= 5; k++) begin
      set_id(1, 32'h400, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 4'd0, 1, 5'd8, 1, 0);
      tick();
      set_id(1, 32'h404, 5'd8, 32'h0, 5'd1, 32'h10, 32'h0, 4'd2, 1, 5'd9, 0, 0);
      #1;
      check($sformatf("sat%0d.stall", k), {31'b0, id_stall}, 32'd1);
      tick();
      check_slot($sformatf("sat%0d", k), 0, 32'h400, 3'b000, 16'(k));
      check($sformatf("sat%0d.sat_cnt", k), {30'b0, s_bubble_cnt}, (k > 3) ? 32'd3 : 32'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
